fpaddsub_normalize_pipe: RTL
============================

Name: fpaddsub_normalize_pipe

Overview:
- Parametrised, pipelined normaliser for the FP add/sub datapath. Sits between the mantissa adder and the rounding stage.
- Counts leading zeros of the mantissa sum, left-shifts the sum so its MSB is set, and adjusts the exponent to match.
- Supports optional gradual underflow (denormal clamp) and valid/ready back-pressure.
- Successor to the single-cycle fixed 26-bit normaliser. Adds a full-range shift, exponent output, zero/denormal flags and a 3-stage pipeline.

Parameters:
- WIDTH, 26, mantissa sum width including carry, hidden bit and GRS bits; bit WIDTH-1 is the MSB.
- EXP_W, 8, exponent width (unsigned, biased).
- SH_W, $clog2(WIDTH), shift-amount width (derived; do not override).
- DENORM_EN, 1, 1 = clamp shift to the input exponent (produce a denormal); 0 = unclamped shift, exponent saturates at 0.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block can accept an input this cycle.
- in_sum, in, WIDTH, unsigned mantissa sum.
- in_exp, in, EXP_W, exponent associated with bit WIDTH-1 of in_sum.
- in_sign, in, 1, sign; passed through unchanged.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts the output.
- out_mant, out, WIDTH, normalised mantissa.
- out_exp, out, EXP_W, adjusted exponent.
- out_shift, out, SH_W, shift amount actually applied.
- out_sign, out, 1, delayed in_sign.
- out_zero, out, 1, in_sum was all zeros.
- out_denorm, out, 1, shift was clamped by the exponent.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid = 0; all output data registers = 0. Reset mid-operation drops all in-flight beats; none are emitted after release.
- Pipeline advance: adv = ~out_valid | out_ready, applied globally to all three stages (no bubble collapsing). in_ready = adv, combinational.
- Acceptance: a beat is accepted when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Latency: 3 cycles from acceptance to out_valid with no stalls. Throughput: 1 beat per cycle.
- While out_valid & ~out_ready, all stage registers and outputs hold stable.
- Stage 1 (leading-zero count and clamp):
  - lz = number of leading zeros of in_sum, range 0..WIDTH-1. lz is WIDTH when in_sum == 0.
  - zero = (in_sum == 0).
  - If zero: shift = 0.
  - Else if DENORM_EN and lz > in_exp: shift = in_exp[SH_W-1:0] and denorm = 1. If in_exp ≥ WIDTH this case cannot occur.
  - Else: shift = lz and denorm = 0.
  - Register sum, exp, sign, shift, zero, denorm.
- Stage 2 (coarse shift): sum <<= shift with the lower 2 bits masked to 0, i.e. shifts in multiples of 4. Register the result.
- Stage 3 (fine shift):
  - Apply sum <<= shift[1:0].
  - out_exp = exp - shift. If DENORM_EN = 0 and shift > exp, out_exp = 0 (saturate, no wrap).
  - If zero: out_mant = 0 and out_exp = 0.
- Shifts fill with zeros from the LSB. out_mant[WIDTH-1] = 1 whenever zero = 0 and denorm = 0.
- Carry case: in_sum[WIDTH-1] = 1 gives shift 0 and an unchanged mantissa.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.
- in_valid deasserted: a bubble propagates. out_valid is low for exactly that slot.

Test Plan (WIDTH=26, EXP_W=8):
- Normalise: in_sum=26'h0000400, in_exp=100 → after 3 cycles out_mant=26'h2000000, out_shift=15, out_exp=85, out_zero=0, out_denorm=0.
- Carry/already normalised: in_sum=26'h3000000, in_exp=7 → out_mant=26'h3000000, out_shift=0, out_exp=7.
- Denormal clamp (DENORM_EN=1): in_sum=26'h0000400, in_exp=5 → out_shift=5, out_mant=26'h0008000, out_exp=0, out_denorm=1. Same input with DENORM_EN=0 → out_shift=15, out_mant=26'h2000000, out_exp=0.
- Zero: in_sum=0, in_exp=200, in_sign=1 → out_zero=1, out_mant=0, out_exp=0, out_shift=0, out_sign=1.
- Back-pressure: stream 6 back-to-back beats, hold out_ready=0 for 4 cycles starting at the first out_valid → in_ready=0 during the stall, outputs stable, all 6 results emitted in order, none lost or duplicated.
- Reset mid-flight: accept 2 beats, assert rst_n=0 asynchronously between edges → out_valid=0 immediately. After release, no stale beat appears; the next input emerges with 3-cycle latency.

Source files
------------

// File: rtl/fpaddsub_normalize_pipe.sv
// Three-stage normaliser for the FP add/sub datapath: leading-zero count with
// optional denormal clamp, coarse (x4) shift, then fine shift and exponent adjust.
module fpaddsub_normalize_pipe #(
    parameter int unsigned WIDTH     = 26,
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned SH_W      = $clog2(WIDTH),
    parameter bit          DENORM_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [SH_W-1:0]  out_shift,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_denorm
);

    logic adv;

    logic [SH_W-1:0] lz_c;
    logic            zero_c;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic             s1_sign_q, s1_sign_d;
    logic [SH_W-1:0]  s1_shift_q, s1_shift_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s1_denorm_q, s1_denorm_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic             s2_sign_q, s2_sign_d;
    logic [SH_W-1:0]  s2_shift_q, s2_shift_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_denorm_q, s2_denorm_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_mant_q, out_mant_d;
    logic [EXP_W-1:0] out_exp_q, out_exp_d;
    logic [SH_W-1:0]  out_shift_q, out_shift_d;
    logic             out_sign_q, out_sign_d;
    logic             out_zero_q, out_zero_d;
    logic             out_denorm_q, out_denorm_d;

    // Whole pipe moves together; a stalled output freezes every stage.
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // Highest set bit wins because the scan runs LSB to MSB.
    always_comb begin
        lz_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_sum[i]) begin
                lz_c = SH_W'(WIDTH - 1 - i);
            end
        end
    end

    assign zero_c = (in_sum == '0);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sum_d     = s1_sum_q;
        s1_exp_d     = s1_exp_q;
        s1_sign_d    = s1_sign_q;
        s1_shift_d   = s1_shift_q;
        s1_zero_d    = s1_zero_q;
        s1_denorm_d  = s1_denorm_q;
        s2_valid_d   = s2_valid_q;
        s2_sum_d     = s2_sum_q;
        s2_exp_d     = s2_exp_q;
        s2_sign_d    = s2_sign_q;
        s2_shift_d   = s2_shift_q;
        s2_zero_d    = s2_zero_q;
        s2_denorm_d  = s2_denorm_q;
        out_valid_d  = out_valid_q;
        out_mant_d   = out_mant_q;
        out_exp_d    = out_exp_q;
        out_shift_d  = out_shift_q;
        out_sign_d   = out_sign_q;
        out_zero_d   = out_zero_q;
        out_denorm_d = out_denorm_q;

        if (adv) begin
            // Stage 1: shift selection, clamped to the exponent for gradual underflow
            s1_valid_d  = in_valid;
            s1_sum_d    = in_sum;
            s1_exp_d    = in_exp;
            s1_sign_d   = in_sign;
            s1_zero_d   = zero_c;
            s1_shift_d  = lz_c;
            s1_denorm_d = 1'b0;
            if (zero_c) begin
                s1_shift_d = '0;
            end else if (DENORM_EN && (32'(lz_c) > 32'(in_exp))) begin
                s1_shift_d  = SH_W'(in_exp);
                s1_denorm_d = 1'b1;
            end

            // Stage 2: coarse shift by the multiple-of-4 part
            s2_valid_d  = s1_valid_q;
            s2_sum_d    = s1_sum_q << (s1_shift_q & ~SH_W'(3));
            s2_exp_d    = s1_exp_q;
            s2_sign_d   = s1_sign_q;
            s2_shift_d  = s1_shift_q;
            s2_zero_d   = s1_zero_q;
            s2_denorm_d = s1_denorm_q;

            // Stage 3: fine shift and exponent adjust (saturating at zero)
            out_valid_d  = s2_valid_q;
            out_mant_d   = s2_sum_q << s2_shift_q[1:0];
            out_shift_d  = s2_shift_q;
            out_sign_d   = s2_sign_q;
            out_zero_d   = s2_zero_q;
            out_denorm_d = s2_denorm_q;
            if (s2_zero_q) begin
                out_mant_d = '0;
                out_exp_d  = '0;
            end else if (!DENORM_EN && (32'(s2_shift_q) > 32'(s2_exp_q))) begin
                out_exp_d = '0;
            end else begin
                out_exp_d = s2_exp_q - EXP_W'(s2_shift_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_exp_q     <= '0;
            s1_sign_q    <= 1'b0;
            s1_shift_q   <= '0;
            s1_zero_q    <= 1'b0;
            s1_denorm_q  <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sum_q     <= '0;
            s2_exp_q     <= '0;
            s2_sign_q    <= 1'b0;
            s2_shift_q   <= '0;
            s2_zero_q    <= 1'b0;
            s2_denorm_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_mant_q   <= '0;
            out_exp_q    <= '0;
            out_shift_q  <= '0;
            out_sign_q   <= 1'b0;
            out_zero_q   <= 1'b0;
            out_denorm_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_q     <= s1_sum_d;
            s1_exp_q     <= s1_exp_d;
            s1_sign_q    <= s1_sign_d;
            s1_shift_q   <= s1_shift_d;
            s1_zero_q    <= s1_zero_d;
            s1_denorm_q  <= s1_denorm_d;
            s2_valid_q   <= s2_valid_d;
            s2_sum_q     <= s2_sum_d;
            s2_exp_q     <= s2_exp_d;
            s2_sign_q    <= s2_sign_d;
            s2_shift_q   <= s2_shift_d;
            s2_zero_q    <= s2_zero_d;
            s2_denorm_q  <= s2_denorm_d;
            out_valid_q  <= out_valid_d;
            out_mant_q   <= out_mant_d;
            out_exp_q    <= out_exp_d;
            out_shift_q  <= out_shift_d;
            out_sign_q   <= out_sign_d;
            out_zero_q   <= out_zero_d;
            out_denorm_q <= out_denorm_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_mant   = out_mant_q;
    assign out_exp    = out_exp_q;
    assign out_shift  = out_shift_q;
    assign out_sign   = out_sign_q;
    assign out_zero   = out_zero_q;
    assign out_denorm = out_denorm_q;

endmodule
